// File: rtl/restoring_div.sv
// restoring_div: iterative radix-2 restoring unsigned divider, 2*WIDTH / WIDTH -> WIDTH quotient + remainder.
// Latency: WIDTH cycles from acceptance to valid_out for a normal divide; 1 cycle for divide-by-zero/overflow.
// Backpressure: ready is high only in IDLE; valid_in while ready=0 is ignored (not queued).
// Ports: clk, rst (sync active-high), dividend/divisor/valid_in (request), ready,
//        quotient/remainder (registered results), valid_out (completion pulse), done (results held),
//        div_by_zero/overflow (exception flags for the held result).
module restoring_div #(
   parameter int WIDTH = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [2*WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0]   divisor,
   input  logic               valid_in,
   output logic               ready,
   output logic [WIDTH-1:0]   quotient,
   output logic [WIDTH-1:0]   remainder,
   output logic               valid_out,
   output logic               done,
   output logic               div_by_zero,
   output logic               overflow
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, BUSY, EXC} state_t;

   state_t           state;
   logic [WIDTH:0]   r;       // partial remainder, one guard bit so the shifted value never truncates
   logic [WIDTH-1:0] q;       // dividend low half shifting out, quotient bits shifting in
   logic [WIDTH-1:0] dvsr;
   logic [CW-1:0]    cnt;
   logic             exc_dz;  // EXC cause: 1 = divide by zero, 0 = quotient overflow

   logic [WIDTH-1:0] div_hi;
   logic [WIDTH-1:0] div_lo;
   logic [WIDTH:0]   t;
   logic [WIDTH:0]   r_nxt;
   logic [WIDTH-1:0] q_nxt;

   assign div_hi = dividend[2*WIDTH-1:WIDTH];
   assign div_lo = dividend[WIDTH-1:0];
   assign ready  = (state == IDLE);

   // One restoring step: shift the next dividend bit into the remainder, subtract if it fits.
   always_comb begin
      t     = {r[WIDTH-1:0], q[WIDTH-1]};
      r_nxt = t;
      q_nxt = {q[WIDTH-2:0], 1'b0};
      if (t >= {1'b0, dvsr}) begin
         r_nxt = t - {1'b0, dvsr};
         q_nxt = {q[WIDTH-2:0], 1'b1};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         r           <= '0;
         q           <= '0;
         dvsr        <= '0;
         cnt         <= '0;
         exc_dz      <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         valid_out   <= 1'b0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         // valid_out is a pulse: only a completion edge below re-asserts it.
         valid_out <= 1'b0;
         case (state)
            IDLE: begin
               if (valid_in) begin
                  dvsr        <= divisor;
                  done        <= 1'b0;
                  div_by_zero <= 1'b0;
                  overflow    <= 1'b0;
                  if (divisor == '0) begin
                     // Low half is parked in q so EXC can return it as the remainder.
                     state  <= EXC;
                     exc_dz <= 1'b1;
                     r      <= '0;
                     q      <= div_lo;
                  end else if (div_hi >= divisor) begin
                     // Quotient would not fit in WIDTH bits.
                     state  <= EXC;
                     exc_dz <= 1'b0;
                     r      <= '0;
                     q      <= div_lo;
                  end else begin
                     state <= BUSY;
                     r     <= {1'b0, div_hi};
                     q     <= div_lo;
                     cnt   <= CW'(WIDTH);
                  end
               end
            end

            BUSY: begin
               r   <= r_nxt;
               q   <= q_nxt;
               cnt <= cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  quotient  <= q_nxt;
                  remainder <= r_nxt[WIDTH-1:0];
                  valid_out <= 1'b1;
                  done      <= 1'b1;
                  state     <= IDLE;
               end
            end

            EXC: begin
               quotient    <= '1;
               remainder   <= exc_dz ? q : '0;
               div_by_zero <= exc_dz;
               overflow    <= ~exc_dz;
               valid_out   <= 1'b1;
               done        <= 1'b1;
               state       <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_restoring_div.sv
module tb_restoring_div;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] dividend = '0;
   logic [15:0] divisor = '0;
   logic        valid_in = 1'b0;
   logic        ready;
   logic [15:0] quotient;
   logic [15:0] remainder;
   logic        valid_out;
   logic        done;
   logic        div_by_zero;
   logic        overflow;

   int n_cmp = 0;
   int n_err = 0;

   restoring_div #(.WIDTH(16)) dut (
      .clk(clk), .rst(rst), .dividend(dividend), .divisor(divisor),
      .valid_in(valid_in), .ready(ready), .quotient(quotient), .remainder(remainder),
      .valid_out(valid_out), .done(done), .div_by_zero(div_by_zero), .overflow(overflow)
   );

   always #5 clk = ~clk;

   // Present a request for one edge; caller is #1 after an edge with ready=1.
   task automatic start(input logic [31:0] dd, input logic [15:0] ds);
      dividend = dd;
      divisor  = ds;
      valid_in = 1'b1;
      @(posedge clk); #1;
      valid_in = 1'b0;
   endtask

   // Count edges until valid_out is seen (sampled #1 after each edge); -1 on timeout.
   task automatic wait_vo(output int lat);
      lat = 0;
      while (!valid_out && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      if (!valid_out) lat = -1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b0;
      n_cmp++; if ({quotient, remainder} !== 32'h0) begin n_err++; $display("FAIL reset_qr got %h/%h want 0/0", quotient, remainder); end
      n_cmp++; if ({valid_out, done, div_by_zero, overflow} !== 4'b0000) begin n_err++; $display("FAIL reset_flags got %b want 0000", {valid_out, done, div_by_zero, overflow}); end
      n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", ready); end
   endtask

   task automatic test_basic;
      int lat;
      start(32'd100, 16'd7);
      n_cmp++; if (ready !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL basic_busy ready=%b done=%b want 0/0", ready, done); end
      wait_vo(lat);
      n_cmp++; if (lat != 16) begin n_err++; $display("FAIL basic_latency got %0d want 16", lat); end
      n_cmp++; if (quotient !== 16'd14 || remainder !== 16'd2) begin n_err++; $display("FAIL basic_qr got %0d/%0d want 14/2", quotient, remainder); end
      n_cmp++; if ({done, div_by_zero, overflow, ready} !== 4'b1001) begin n_err++; $display("FAIL basic_flags got %b want 1001", {done, div_by_zero, overflow, ready}); end
      repeat (3) @(posedge clk);
      #1;
      n_cmp++; if (done !== 1'b1 || valid_out !== 1'b0 || quotient !== 16'd14) begin n_err++; $display("FAIL basic_hold done=%b vo=%b q=%0d want 1/0/14", done, valid_out, quotient); end
   endtask

   task automatic test_full_range;
      int lat;
      start(32'hFFFE0001, 16'hFFFF);
      wait_vo(lat);
      n_cmp++; if (lat != 16 || quotient !== 16'hFFFF || remainder !== 16'h0) begin n_err++; $display("FAIL full_a lat=%0d q=%h r=%h want 16/ffff/0000", lat, quotient, remainder); end
      start(32'h0001FFFE, 16'd2);
      wait_vo(lat);
      n_cmp++; if (lat != 16 || quotient !== 16'hFFFF || remainder !== 16'h0) begin n_err++; $display("FAIL full_b lat=%0d q=%h r=%h want 16/ffff/0000", lat, quotient, remainder); end
      n_cmp++; if (div_by_zero !== 1'b0 || overflow !== 1'b0) begin n_err++; $display("FAIL full_flags dz=%b ov=%b want 0/0", div_by_zero, overflow); end
   endtask

   task automatic test_exceptions;
      int lat;
      start(32'h00001234, 16'd0);
      wait_vo(lat);
      n_cmp++; if (lat != 1) begin n_err++; $display("FAIL dz_latency got %0d want 1", lat); end
      n_cmp++; if (quotient !== 16'hFFFF || remainder !== 16'h1234) begin n_err++; $display("FAIL dz_qr got %h/%h want ffff/1234", quotient, remainder); end
      n_cmp++; if ({done, div_by_zero, overflow} !== 3'b110) begin n_err++; $display("FAIL dz_flags got %b want 110", {done, div_by_zero, overflow}); end
      start(32'h00010000, 16'd1);
      wait_vo(lat);
      n_cmp++; if (lat != 1) begin n_err++; $display("FAIL ov_latency got %0d want 1", lat); end
      n_cmp++; if (quotient !== 16'hFFFF || remainder !== 16'h0) begin n_err++; $display("FAIL ov_qr got %h/%h want ffff/0000", quotient, remainder); end
      n_cmp++; if ({done, div_by_zero, overflow} !== 3'b101) begin n_err++; $display("FAIL ov_flags got %b want 101", {done, div_by_zero, overflow}); end
      // Both conditions: zero divisor with nonzero high half -> div_by_zero wins.
      start(32'h00050007, 16'd0);
      wait_vo(lat);
      n_cmp++; if ({div_by_zero, overflow} !== 2'b10 || remainder !== 16'h0007) begin n_err++; $display("FAIL both_flags dz=%b ov=%b r=%h want 1/0/0007", div_by_zero, overflow, remainder); end
   endtask

   task automatic test_back_to_back;
      int lat;
      int pulses;
      start(32'd1000, 16'd10);          // accepted at edge N, now N+#1
      repeat (2) @(posedge clk);
      #1;
      n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL busy_ready got %b want 0", ready); end
      start(32'd5, 16'd5);              // ignored: presented at edge N+3 while BUSY
      dividend = 32'hDEAD_BEEF;         // inputs may change freely during BUSY
      divisor  = 16'h0000;
      wait_vo(lat);
      n_cmp++; if (lat != 13) begin n_err++; $display("FAIL ignore_latency got %0d want 13", lat); end
      n_cmp++; if (quotient !== 16'd100 || remainder !== 16'd0 || div_by_zero !== 1'b0) begin n_err++; $display("FAIL ignore_qr got %0d/%0d dz=%b want 100/0/0", quotient, remainder, div_by_zero); end
      n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready got %b want 1", ready); end
      start(32'd5, 16'd5);              // accepted in the valid_out cycle
      n_cmp++; if (valid_out !== 1'b0 || done !== 1'b0 || ready !== 1'b0) begin n_err++; $display("FAIL b2b_accept vo=%b done=%b ready=%b want 0/0/0", valid_out, done, ready); end
      n_cmp++; if (quotient !== 16'd100 || remainder !== 16'd0) begin n_err++; $display("FAIL b2b_hold got %0d/%0d want 100/0", quotient, remainder); end
      pulses = 0;
      lat = 0;
      while (lat < 16) begin
         @(posedge clk); #1;
         lat++;
         if (valid_out) pulses++;
      end
      n_cmp++; if (pulses != 1 || valid_out !== 1'b1) begin n_err++; $display("FAIL b2b_pulse got %0d pulses vo=%b want 1/1", pulses, valid_out); end
      n_cmp++; if (quotient !== 16'd1 || remainder !== 16'd0) begin n_err++; $display("FAIL b2b_qr got %0d/%0d want 1/0", quotient, remainder); end
   endtask

   task automatic test_reset_mid;
      int lat;
      int pulses;
      start(32'h0000FFFF, 16'd3);
      repeat (7) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      n_cmp++; if ({quotient, remainder} !== 32'h0 || {valid_out, done, div_by_zero, overflow} !== 4'b0) begin n_err++; $display("FAIL midrst_outs q=%h r=%h flags=%b want 0", quotient, remainder, {valid_out, done, div_by_zero, overflow}); end
      n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL midrst_ready got %b want 1", ready); end
      pulses = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (valid_out) pulses++;
      end
      n_cmp++; if (pulses != 0) begin n_err++; $display("FAIL midrst_novo got %0d pulses want 0", pulses); end
      start(32'd49, 16'd7);
      wait_vo(lat);
      n_cmp++; if (lat != 16 || quotient !== 16'd7 || remainder !== 16'd0) begin n_err++; $display("FAIL midrst_next lat=%0d q=%0d r=%0d want 16/7/0", lat, quotient, remainder); end
   endtask

   task automatic test_random;
      int lat;
      logic [15:0] ds;
      logic [31:0] dd;
      logic [15:0] eq;
      logic [15:0] er;
      for (int i = 0; i < 200; i++) begin
         ds = 16'($urandom_range(1, 65535));
         dd = {16'($urandom % ds), 16'($urandom)};
         eq = 16'(dd / {16'h0, ds});
         er = 16'(dd % {16'h0, ds});
         start(dd, ds);
         wait_vo(lat);
         n_cmp++;
         if (lat != 16 || quotient !== eq || remainder !== er || div_by_zero !== 1'b0 || overflow !== 1'b0) begin
            n_err++;
            $display("FAIL rand_%0d %h/%h lat=%0d got %h r %h want %h r %h", i, dd, ds, lat, quotient, remainder, eq, er);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_full_range();
      test_exceptions();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
